tfc_conflict_monitor: RTL
=========================

Name: tfc_conflict_monitor

Overview:
Safety stage directly downstream of the traffic light controller (tfc). It consumes the controller's NS/EW light codes and checks every cycle for conflicting greens, invalid codes, illegal sequences, short yellows and stuck phases. Clean codes pass through, registered, to the lamp drivers. On any fault it latches a fault code and forces both heads into flashing red until an operator clear.

Parameters:
MIN_YELLOW, 2, minimum consecutive YELLOW cycles required before a head leaves YELLOW
MAX_HOLD, 64, maximum consecutive cycles any head may hold one code (watchdog)
STARTUP_CYC, 4, cycles of forced all-red after reset or after a fault clear
FLASH_HALF, 5, cycles per half-period of the fault flash (RED for FLASH_HALF, DARK for FLASH_HALF)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
NS  input  2  north-south light code from the controller
EW  input  2  east-west light code from the controller
fault_clr  input  1  operator fault clear, level-sampled
NS_out  output  2  north-south lamp drive
EW_out  output  2  east-west lamp drive
fault  output  1  high while in FAULT
fault_code  output  3  latched cause of the first fault; 0 = none
flash  output  1  high while lamps are flashing

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Input codes: 00 RED, 01 GREEN, 10 YELLOW, 11 invalid.
- Lamp codes on NS_out/EW_out: same encoding, but 11 means DARK (lamp off).
- Reset values: NS_out=EW_out=00, fault=0, fault_code=0, flash=0, state=INIT, all counters 0.
- States: INIT, MONITOR, FAULT.
- INIT:
  - Outputs both 00.
  - startup counter increments every cycle.
  - Go to MONITOR once the counter reaches STARTUP_CYC-1 AND the current inputs pass checks 1 and 2.
  - On that transition, prev_NS/prev_EW are loaded with the current inputs and the run counters are cleared.
  - If inputs are still bad, remain in INIT with the counter saturated.
- MONITOR:
  - Checks are combinational on the current inputs versus the registered previous inputs.
  - Pass-through: NS_out/EW_out = NS/EW registered, so latency is 1 cycle.
- Checks, evaluated in MONITOR; if several fire in one cycle, the lowest code wins:
  1. Conflict: NS!=RED and EW!=RED in the same cycle.
  2. Invalid: NS==11 or EW==11.
  3. Illegal transition on either head: GREEN->RED, RED->YELLOW, YELLOW->GREEN. Legal changes are RED->GREEN, GREEN->YELLOW, YELLOW->RED.
  4. Short yellow: a head leaves YELLOW with its run count < MIN_YELLOW.
  5. Stuck: either head's run count reaches MAX_HOLD.
- Run counters: one per head. Reset to 1 when the head's code changes, otherwise increment; they saturate at MAX_HOLD.
- On violation:
  - The next edge enters FAULT, sets fault=1 and latches fault_code.
  - The offending pattern is never driven to the lamps; the first FAULT cycle outputs RED/RED.
- FAULT:
  - flash=1; both outputs alternate 00 for FLASH_HALF cycles, then 11 for FLASH_HALF cycles, repeating, starting with 00.
  - Inputs are ignored apart from the clear qualification.
  - fault_code holds its value; a later violation does not overwrite it.
- Clear:
  - fault_clr is honoured only in FAULT and only when NS==00 and EW==00 in that cycle.
  - Then go to INIT with fault=0, fault_code=0, flash=0 and the counters cleared.
  - fault_clr in INIT or MONITOR has no effect.
- Reset mid-operation: immediate asynchronous return to all reset values from any state, including mid-flash.

Decomposition:
- Package tfc_pkg holds:
  - light code constants RED/GREEN/YELLOW/INVALID_DARK
  - fault code constants FC_NONE=0, FC_CONFLICT=1, FC_INVALID=2, FC_SEQ=3, FC_SHORT_Y=4, FC_STUCK=5
  - state encoding INIT/MONITOR/FAULT
- The upstream tfc imports the same light codes from tfc_pkg.
- One sub-module, tfc_flasher: enable input, FLASH_HALF-cycle toggle counter, phase output. It restarts in phase RED whenever enable rises.

Test Plan:
- Reset, then hold NS=00/EW=00 → outputs 00/00 for 4 cycles. Then drive NS=01/EW=00 → NS_out=01 one cycle later, fault=0.
- In MONITOR, drive NS=01 and EW=01 together → next edge: fault=1, fault_code=1, outputs 00/00. Then 00 for 5 cycles, 11 for 5, 00 again; flash=1.
- Drive NS sequence 01,01,00 (GREEN->RED) → fault_code=3.
- Drive NS 01,10,00 (one YELLOW cycle, MIN_YELLOW=2) → fault_code=4. Repeat with 01,10,10,00 → no fault.
- Hold NS=01/EW=00 for 64 cycles → fault_code=5 on the edge where the run count reaches 64.
- In FAULT, assert fault_clr with NS=01 → stays in FAULT. Then NS=EW=00 with fault_clr=1 → INIT, fault=0, code=0, then 4 all-red cycles. Assert rst_n=0 mid-flash → outputs 00 asynchronously.

Source files
------------

// File: rtl/tfc_pkg.sv
// rtl/tfc_pkg.sv - shared light codes, fault codes and monitor state encoding
package tfc_pkg;

  localparam logic [1:0] RED          = 2'b00;
  localparam logic [1:0] GREEN        = 2'b01;
  localparam logic [1:0] YELLOW       = 2'b10;
  localparam logic [1:0] INVALID_DARK = 2'b11;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_CONFLICT = 3'd1;
  localparam logic [2:0] FC_INVALID  = 3'd2;
  localparam logic [2:0] FC_SEQ      = 3'd3;
  localparam logic [2:0] FC_SHORT_Y  = 3'd4;
  localparam logic [2:0] FC_STUCK    = 3'd5;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    MONITOR = 2'd1,
    FAULT   = 2'd2
  } mon_state_e;

  // Only the three forbidden steps; moves into 11 are caught by the invalid check.
  function automatic logic illegal_step(input logic [1:0] prev, input logic [1:0] cur);
    return ((prev == GREEN)  && (cur == RED))    ||
           ((prev == RED)    && (cur == YELLOW)) ||
           ((prev == YELLOW) && (cur == GREEN));
  endfunction

endpackage

// File: rtl/tfc_flasher.sv
// rtl/tfc_flasher.sv - fault flash phase generator, phase 0 = RED, 1 = DARK
module tfc_flasher #(
  parameter int FLASH_HALF = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic phase
);

  localparam int CW = $clog2(FLASH_HALF + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(FLASH_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // Held in reset while disabled so every new fault starts on a full RED half.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!enable) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == HALF_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/tfc_conflict_monitor.sv
// rtl/tfc_conflict_monitor.sv - safety checker between the tfc and the lamp drivers
module tfc_conflict_monitor
  import tfc_pkg::*;
#(
  parameter int MIN_YELLOW  = 2,
  parameter int MAX_HOLD    = 64,
  parameter int STARTUP_CYC = 4,
  parameter int FLASH_HALF  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] NS,
  input  logic [1:0] EW,
  input  logic       fault_clr,
  output logic [1:0] NS_out,
  output logic [1:0] EW_out,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash
);

  localparam int RW = $clog2(MAX_HOLD + 1);
  localparam int SW = $clog2(STARTUP_CYC + 1);
  localparam logic [RW-1:0] MAX_C      = RW'(MAX_HOLD);
  localparam logic [RW-1:0] MIN_Y_C    = RW'(MIN_YELLOW);
  localparam logic [SW-1:0] START_LAST = SW'(STARTUP_CYC - 1);

  mon_state_e    state_q, state_d;
  logic [SW-1:0] start_cnt_q, start_cnt_d;
  logic [1:0]    prev_ns_q, prev_ns_d, prev_ew_q, prev_ew_d;
  logic [RW-1:0] ns_run_q, ns_run_d, ew_run_q, ew_run_d;
  logic [1:0]    ns_out_q, ns_out_d, ew_out_q, ew_out_d;
  logic [2:0]    fault_code_q, fault_code_d;

  logic          conflict, invalid, seq_bad, short_y, stuck;
  logic [RW-1:0] ns_run_nxt, ew_run_nxt;
  logic [2:0]    viol_code;
  logic          flash_phase;

  always_comb begin
    conflict = (NS != RED) && (EW != RED);
    invalid  = (NS == INVALID_DARK) || (EW == INVALID_DARK);
    seq_bad  = illegal_step(prev_ns_q, NS) || illegal_step(prev_ew_q, EW);
    short_y  = ((prev_ns_q == YELLOW) && (NS != YELLOW) && (ns_run_q < MIN_Y_C)) ||
               ((prev_ew_q == YELLOW) && (EW != YELLOW) && (ew_run_q < MIN_Y_C));

    ns_run_nxt = (NS != prev_ns_q) ? RW'(1) : ((ns_run_q == MAX_C) ? MAX_C : ns_run_q + 1'b1);
    ew_run_nxt = (EW != prev_ew_q) ? RW'(1) : ((ew_run_q == MAX_C) ? MAX_C : ew_run_q + 1'b1);
    stuck      = (ns_run_nxt == MAX_C) || (ew_run_nxt == MAX_C);

    if (conflict)     viol_code = FC_CONFLICT;
    else if (invalid) viol_code = FC_INVALID;
    else if (seq_bad) viol_code = FC_SEQ;
    else if (short_y) viol_code = FC_SHORT_Y;
    else if (stuck)   viol_code = FC_STUCK;
    else              viol_code = FC_NONE;
  end

  always_comb begin
    state_d      = state_q;
    start_cnt_d  = start_cnt_q;
    prev_ns_d    = prev_ns_q;
    prev_ew_d    = prev_ew_q;
    ns_run_d     = ns_run_q;
    ew_run_d     = ew_run_q;
    ns_out_d     = RED;
    ew_out_d     = RED;
    fault_code_d = fault_code_q;

    unique case (state_q)
      INIT: begin
        if (start_cnt_q != START_LAST) start_cnt_d = start_cnt_q + 1'b1;
        if ((start_cnt_q == START_LAST) && !conflict && !invalid) begin
          state_d   = MONITOR;
          prev_ns_d = NS;
          prev_ew_d = EW;
          ns_run_d  = '0;
          ew_run_d  = '0;
        end
      end
      MONITOR: begin
        prev_ns_d = NS;
        prev_ew_d = EW;
        ns_run_d  = ns_run_nxt;
        ew_run_d  = ew_run_nxt;
        if (viol_code != FC_NONE) begin
          state_d      = FAULT;
          fault_code_d = viol_code;
        end else begin
          ns_out_d = NS;
          ew_out_d = EW;
        end
      end
      FAULT: begin
        start_cnt_d = '0;
        ns_run_d    = '0;
        ew_run_d    = '0;
        if (fault_clr && (NS == RED) && (EW == RED)) begin
          state_d      = INIT;
          fault_code_d = FC_NONE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      start_cnt_q  <= '0;
      prev_ns_q    <= RED;
      prev_ew_q    <= RED;
      ns_run_q     <= '0;
      ew_run_q     <= '0;
      ns_out_q     <= RED;
      ew_out_q     <= RED;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      start_cnt_q  <= start_cnt_d;
      prev_ns_q    <= prev_ns_d;
      prev_ew_q    <= prev_ew_d;
      ns_run_q     <= ns_run_d;
      ew_run_q     <= ew_run_d;
      ns_out_q     <= ns_out_d;
      ew_out_q     <= ew_out_d;
      fault_code_q <= fault_code_d;
    end
  end

  tfc_flasher #(.FLASH_HALF(FLASH_HALF)) u_flasher (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state_q == FAULT),
    .phase  (flash_phase)
  );

  // In FAULT the lamps follow the flasher; ns_out_q is RED there so the first cycle is RED.
  assign flash      = (state_q == FAULT);
  assign fault      = (state_q == FAULT);
  assign fault_code = fault_code_q;
  assign NS_out     = flash ? (flash_phase ? INVALID_DARK : RED) : ns_out_q;
  assign EW_out     = flash ? (flash_phase ? INVALID_DARK : RED) : ew_out_q;

endmodule
